pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The parameter list SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, PC and target width in bits.
- RESET_VEC, 32'h00000000, PC value while fetch is disabled; truncated to ADDR_W.
- INST_BYTES, 4, sequential increment (power of two, ≥1).
- STALL_W, 6, width of the stall vector; only bit 0 is used.

REQ-002 The port list SHALL be, one per line (name  direction  width  meaning), clock and reset first:
- clk  input  1  sole clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  STALL_W  pipeline stall vector; stall[0]=1 freezes PC.
- flush  input  1  exception/flush request, redirect to new_pc.
- new_pc  input  ADDR_W  flush redirect address.
- branch_flag_i  input  1  ID-stage branch taken.
- branch_target_address_i  input  ADDR_W  ID-stage branch target.
- pc  output  ADDR_W  current fetch address (registered).
- ce  output  1  instruction-memory chip enable (registered).
- branch_pending_o  output  1  a branch target is buffered awaiting stall release.
- pc_misalign_o  output  1  pc not aligned to INST_BYTES.

Function
REQ-003 ce SHALL be 0 during reset and SHALL become 1 on the first rising clk edge after rst deasserts, then stay 1.
REQ-004 While ce=0, pc SHALL hold RESET_VEC, the pending buffer SHALL stay empty, and all inputs SHALL be ignored.
REQ-005 With ce=1, pc SHALL update on each rising clk edge by the first matching rule, highest priority first: flush, then stall, then branch, then pending, then sequential.
REQ-006 flush=1 SHALL load new_pc into pc and clear the pending buffer, regardless of stall and branch_flag_i.
REQ-007 stall[0]=1 (no flush) SHALL hold pc unchanged.
REQ-008 branch_flag_i=1 while stall[0]=1 (no flush) SHALL write branch_target_address_i into the one-entry pending buffer and set branch_pending_o the next cycle.
REQ-009 A later stalled branch SHALL overwrite the pending target; the latest branch wins.
REQ-010 stall[0]=0 with branch_flag_i=1 SHALL load branch_target_address_i into pc and clear pending; a live branch overrides a buffered one.
REQ-011 stall[0]=0, branch_flag_i=0 and pending set SHALL load the pending target into pc and clear pending in the same edge.
REQ-012 Otherwise pc SHALL advance by INST_BYTES, modulo 2^ADDR_W; wrap from the top address to 0 is silent.
REQ-013 branch_pending_o SHALL be the registered pending-valid bit, with no combinational path from inputs.
REQ-014 pc_misalign_o SHALL be 1 when pc[log2(INST_BYTES)-1:0]≠0, combinational from pc only.
REQ-015 pc_misalign_o SHALL be 0 when INST_BYTES=1.
REQ-016 Misaligned targets SHALL still be loaded; pc_misalign_o only flags them, and exception handling is downstream.

Reset
REQ-017 Asserting rst at any time, including mid-stall with a branch pending, SHALL immediately force pc=RESET_VEC, ce=0, branch_pending_o=0, and pending target=0, without waiting for clk.
REQ-018 No other state SHALL exist; after reset release, behaviour SHALL be identical to power-up.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (defaults unless noted):
- V1 Reset release, no stall or branch -> cycle 1: ce=1, pc=0; then pc=4, 8, 12 on successive edges.
- V2 pc=0x10, stall[0]=1 for 3 cycles, branch_flag_i=1 with target 0x200 in stall cycle 2 -> pc holds 0x10, branch_pending_o=1, pc=0x200 on the first unstalled edge, then 0x204.
- V3 Stall with pending target 0x200, branch to 0x300 on the release cycle -> pc=0x300, pending cleared.
- V4 Stall and branch (target 0x40) together with flush=1, new_pc=0x80 -> pc=0x80 next edge, branch_pending_o=0.
- V5 ADDR_W=8, pc=0xFC, no stall -> pc=0x00; branch target 0x42 -> pc_misalign_o=1.
- V6 rst pulsed between clk edges with branch_pending_o=1 -> pc=RESET_VEC and ce=0 immediately; sequential fetch resumes from RESET_VEC after release.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: flush > stall > branch > buffered branch > sequential,
// with a one-entry buffer holding a branch target that arrived during a stall.
module pc_gen #(
    parameter int              ADDR_W     = 32,
    parameter logic [31:0]     RESET_VEC  = 32'h00000000,
    parameter int              INST_BYTES = 4,
    parameter int              STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               branch_pending_o,
    output logic               pc_misalign_o
);

    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);
    localparam int                OFS_W  = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;

    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce       <= 1'b0;
            pc       <= RST_PC;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
        end else begin
            ce <= 1'b1;
            // The edge that raises ce still presents RESET_VEC as the first fetch.
            if (ce) begin
                if (flush) begin
                    pc       <= new_pc;
                    pend_vld <= 1'b0;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        pend_tgt <= branch_target_address_i;
                        pend_vld <= 1'b1;
                    end
                end else if (branch_flag_i) begin
                    pc       <= branch_target_address_i;
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    pc       <= pend_tgt;
                    pend_vld <= 1'b0;
                end else begin
                    pc <= pc + STEP;
                end
            end
        end
    end

    assign branch_pending_o = pend_vld;

    generate
        if (INST_BYTES > 1) begin : g_mis
            assign pc_misalign_o = |pc[OFS_W-1:0];
        end else begin : g_nomis
            assign pc_misalign_o = 1'b0;
        end

        // Only stall[0] matters; the upper bits belong to other pipeline stages.
        if (STALL_W > 1) begin : g_stall_hi
            logic unused_stall_hi;
            assign unused_stall_hi = |stall[STALL_W-1:1];
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Randomized + directed bench for pc_gen: a 32-bit instance and an 8-bit
// instance share stimulus; the 8-bit PC is the low byte of the reference PC.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;

    logic [31:0] pc32;
    logic        ce32, pend32, mis32;
    logic [7:0]  pc8;
    logic        ce8, pend8, mis8;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [31:0]  m_pc;
    logic         m_ce;
    logic [31:0]  pend_q[$];

    pc_gen dut32 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(br), .branch_target_address_i(tgt),
        .pc(pc32), .ce(ce32), .branch_pending_o(pend32), .pc_misalign_o(mis32)
    );

    pc_gen #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc[7:0]),
        .branch_flag_i(br), .branch_target_address_i(tgt[7:0]),
        .pc(pc8), .ce(ce8), .branch_pending_o(pend8), .pc_misalign_o(mis8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] lo;
        lo = m_pc[7:0];
        chk({tag, ".pc"},    pc32,            m_pc);
        chk({tag, ".ce"},    {31'd0, ce32},   {31'd0, m_ce});
        chk({tag, ".pend"},  {31'd0, pend32}, {31'd0, pend_q.size() != 0});
        chk({tag, ".mis"},   {31'd0, mis32},  {31'd0, (m_pc % 4) != 0});
        chk({tag, ".pc8"},   {24'd0, pc8},    {24'd0, lo});
        chk({tag, ".ce8"},   {31'd0, ce8},    {31'd0, m_ce});
        chk({tag, ".pend8"}, {31'd0, pend8},  {31'd0, pend_q.size() != 0});
        chk({tag, ".mis8"},  {31'd0, mis8},   {31'd0, (lo % 4) != 0});
    endtask

    // Apply one cycle of inputs, advance the reference model, then compare.
    task automatic step(input string tag, input logic s, input logic f, input logic [31:0] np,
                        input logic b, input logic [31:0] bt);
        stall  = {5'($urandom), s};
        flush  = f;
        new_pc = np;
        br     = b;
        tgt    = bt;
        @(posedge clk);
        if (!m_ce) begin
            m_ce = 1'b1;
        end else if (f) begin
            m_pc = np;
            pend_q.delete();
        end else if (s) begin
            if (b) begin
                pend_q.delete();
                pend_q.push_back(bt);
            end
        end else if (b) begin
            m_pc = bt;
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            m_pc = pend_q.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
        #1;
        chk_model(tag);
    endtask

    // Pulse reset between edges and check the asynchronous effect at once.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        m_pc = 32'd0;
        m_ce = 1'b0;
        pend_q.delete();
        chk_model(tag);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; br = 1'b0; tgt = '0;
        m_pc = 32'd0; m_ce = 1'b0; pend_q.delete();
        #12;
        chk_model("reset");
        rst = 1'b0;

        // V1: first fetch is RESET_VEC, then sequential
        step("v1a", 0, 0, 0, 0, 0);
        chk("v1.ce1", {31'd0, ce32}, 32'd1);
        chk("v1.pc0", pc32, 32'h0);
        step("v1b", 0, 0, 0, 0, 0); chk("v1.pc4",  pc32, 32'h4);
        step("v1c", 0, 0, 0, 0, 0); chk("v1.pc8",  pc32, 32'h8);
        step("v1d", 0, 0, 0, 0, 0); chk("v1.pc12", pc32, 32'hC);
        step("v1e", 0, 0, 0, 0, 0); chk("v1.pc16", pc32, 32'h10);

        // V2: branch captured during a stall, taken on release
        step("v2a", 1, 0, 0, 0, 0);      chk("v2.hold1", pc32, 32'h10);
        step("v2b", 1, 0, 0, 1, 32'h200); chk("v2.hold2", pc32, 32'h10);
        chk("v2.pend", {31'd0, pend32}, 32'd1);
        step("v2c", 1, 0, 0, 0, 0);      chk("v2.hold3", pc32, 32'h10);
        step("v2d", 0, 0, 0, 0, 0);      chk("v2.tgt", pc32, 32'h200);
        chk("v2.clr", {31'd0, pend32}, 32'd0);
        step("v2e", 0, 0, 0, 0, 0);      chk("v2.next", pc32, 32'h204);

        // Later stalled branch overwrites the buffered one
        step("ow1", 1, 0, 0, 1, 32'h500);
        step("ow2", 1, 0, 0, 1, 32'h600);
        step("ow3", 0, 0, 0, 0, 0);      chk("ow.latest", pc32, 32'h600);

        // V3: live branch on release beats the buffered target
        step("v3a", 1, 0, 0, 1, 32'h200);
        step("v3b", 0, 0, 0, 1, 32'h300); chk("v3.pc", pc32, 32'h300);
        chk("v3.clr", {31'd0, pend32}, 32'd0);

        // V4: flush beats stall and branch, and drops a buffered target
        step("v4a", 1, 0, 0, 1, 32'h700);
        step("v4b", 1, 1, 32'h80, 1, 32'h40); chk("v4.pc", pc32, 32'h80);
        chk("v4.clr", {31'd0, pend32}, 32'd0);
        step("v4c", 0, 0, 0, 0, 0);      chk("v4.next", pc32, 32'h84);

        // V5: 8-bit wrap, misaligned target; 32-bit wrap
        step("v5a", 0, 1, 32'hFC, 0, 0);
        step("v5b", 0, 0, 0, 0, 0);      chk("v5.wrap8", {24'd0, pc8}, 32'h0);
        step("v5c", 0, 0, 0, 1, 32'h42); chk("v5.mis8", {31'd0, mis8}, 32'd1);
        chk("v5.pc8", {24'd0, pc8}, 32'h42);
        step("v5d", 0, 1, 32'hFFFF_FFFC, 0, 0);
        step("v5e", 0, 0, 0, 0, 0);      chk("v5.wrap32", pc32, 32'h0);

        // V6: async reset while a branch is pending
        step("v6a", 1, 0, 0, 1, 32'h900);
        chk("v6.pend", {31'd0, pend32}, 32'd1);
        pulse_reset("v6rst");
        chk("v6.ce0", {31'd0, ce32}, 32'd0);
        step("v6b", 0, 0, 0, 0, 0);      chk("v6.pc0", pc32, 32'h0);
        step("v6c", 0, 0, 0, 0, 0);      chk("v6.pc4", pc32, 32'h4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t, n;
            t = $urandom;
            n = $urandom;
            if ($urandom_range(7) != 0) t = t & ~32'h3;
            if ($urandom_range(7) != 0) n = n & ~32'h3;
            if ($urandom_range(99) == 0)
                pulse_reset("rrst");
            step("rand", $urandom_range(9) < 4, $urandom_range(19) == 0, n,
                 $urandom_range(9) < 3, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
